popcount_frame_ctrl: RTL

//  Frame-level controller around a combinational ones-counter. Accepts a stream of WIDTH-bit words

---
 rtl/popcount_frame_ctrl_pkg.sv | 26 ++
 rtl/popcount_frame_ctrl_if.sv | 35 +++
 rtl/popcount_frame_ctrl_popcount_unit.sv | 20 ++
 rtl/popcount_frame_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/popcount_frame_ctrl_pkg.sv
// Shared types and width helpers for the frame-level popcount controller.
// Imported by the interface, the ones-counter and the top.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Width of a single-word ones count.
    function automatic int pc_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Width of the saturating word counter.
    function automatic int wc_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

    // Width of the ones/zeros totals.
    function automatic int tot_width(input int max_words, input int width);
        return $clog2(max_words * width + 1);
    endfunction

endpackage

// File: rtl/popcount_frame_ctrl_if.sv
// Input word stream and result stream of the popcount frame controller.
// The slave side is the controller; the master side is its environment.
interface popcount_frame_ctrl_if
    import popcount_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16
) ();

    localparam int WC_W  = wc_width(MAX_WORDS);
    localparam int TOT_W = tot_width(MAX_WORDS, WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [TOT_W-1:0] out_ones;
    logic [TOT_W-1:0] out_zeros;
    logic [WC_W-1:0]  out_words;
    logic             out_overflow;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_ones, out_zeros, out_words, out_overflow
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_ones, out_zeros, out_words, out_overflow
    );

endinterface

// File: rtl/popcount_frame_ctrl_popcount_unit.sv
// Purely combinational ones counter for a single WIDTH-bit word.
module popcount_unit
    import popcount_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int PC_W = pc_width(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic [PC_W-1:0]  count
);

    always_comb begin
        // NOTE: assign a default before the loop so every path drives count and no latch is inferred.
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + PC_W'(data[i]);
        end
    end

endmodule

// File: rtl/popcount_frame_ctrl.sv
// Frame controller: accumulates ones per frame of input words and presents
// registered totals over a result handshake.
module popcount_frame_ctrl
    import popcount_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_clr,
    popcount_frame_ctrl_if.slave  bus
);

    localparam int PC_W  = pc_width(WIDTH);
    localparam int WC_W  = wc_width(MAX_WORDS);
    localparam int TOT_W = tot_width(MAX_WORDS, WIDTH);

    localparam logic [WC_W-1:0]  MAX_WORDS_C = WC_W'(MAX_WORDS);
    localparam logic [TOT_W-1:0] WIDTH_C     = TOT_W'(WIDTH);

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [TOT_W-1:0]  ones_q, ones_d;
    logic [WC_W-1:0]   words_q, words_d;
    logic              ovf_q, ovf_d;

    logic [PC_W-1:0]   word_ones;
    logic              in_ready;
    logic              accept;
    logic              result_taken;

    popcount_unit #(.WIDTH(WIDTH)) u_popcount (
        .data  (bus.in_data),
        .count (word_ones)
    );

    // soft_clr must block a same-cycle word, so it gates the registered ready.
    assign in_ready     = in_ready_q && !soft_clr;
    assign accept       = bus.in_valid && in_ready;
    assign result_taken = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        ones_d      = ones_q;
        words_d     = words_q;
        ovf_d       = ovf_q;

        if (soft_clr) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            ones_d      = '0;
            words_d     = '0;
            ovf_d       = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        // Words beyond MAX_WORDS are consumed but only flag overflow.
                        if (words_q < MAX_WORDS_C) begin
                            ones_d  = ones_q + TOT_W'(word_ones);
                            words_d = words_q + WC_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                        if (bus.in_last) begin
                            state_d     = DONE;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (result_taken) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        ones_d      = '0;
                        words_d     = '0;
                        ovf_d       = 1'b0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end

        // Ready is registered from the next state, giving the one-bubble turnaround.
        in_ready_d = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ones_q      <= '0;
            words_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ones_q      <= ones_d;
            words_q     <= words_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_ones     = ones_q;
    assign bus.out_words    = words_q;
    assign bus.out_overflow = ovf_q;
    // Counted bits never fall below the ones total, so this cannot underflow.
    assign bus.out_zeros    = (TOT_W'(words_q) * WIDTH_C) - ones_q;

endmodule
